local_injector: RTL and testbench

LOCAL_INJECTOR -- requirements
Module: local_injector

---
 rtl/local_injector_if.sv | 27 ++
 rtl/local_injector.sv | 89 ++++++++
 tb/tb_local_injector.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/local_injector_if.sv
// Local-port bus between a packet source and the injector: request,
// payload stream, router back-pressure, and the flit/status outputs.
interface local_injector_if;
    logic        req_valid_i;
    logic [3:0]  req_dest_i;
    logic [2:0]  req_len_i;
    logic        req_ready_o;
    logic        pay_valid_i;
    logic [14:0] pay_data_i;
    logic        pay_ready_o;
    logic        full_i;
    logic [16:0] flit_o;
    logic        busy_o;
    logic [7:0]  pkt_cnt_o;

    // Injector side
    modport slave (
        input  req_valid_i, req_dest_i, req_len_i, pay_valid_i, pay_data_i, full_i,
        output req_ready_o, pay_ready_o, flit_o, busy_o, pkt_cnt_o
    );

    // Packet source / router side
    modport master (
        output req_valid_i, req_dest_i, req_len_i, pay_valid_i, pay_data_i, full_i,
        input  req_ready_o, pay_ready_o, flit_o, busy_o, pkt_cnt_o
    );
endinterface

// File: rtl/local_injector.sv
// Local injector: turns a (dest, len) request plus a payload stream into
// one header flit followed by len body flits on the router local input.
// Every flit is registered and valid for exactly one cycle.
module local_injector #(
    parameter logic [3:0] SRC_ID = 4'd0
) (
    input  logic              clk,
    input  logic              rst,
    local_injector_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

    state_t      state_q, state_d;
    logic [3:0]  dest_q,  dest_d;
    logic [2:0]  len_q,   len_d;
    logic [2:0]  rem_q,   rem_d;
    logic [16:0] flit_q,  flit_d;
    logic [7:0]  cnt_q,   cnt_d;

    assign bus.req_ready_o = (state_q == IDLE);
    assign bus.pay_ready_o = (state_q == BODY) & ~bus.full_i;
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.flit_o      = flit_q;
    assign bus.pkt_cnt_o   = cnt_q;

    // Next-state and next-flit logic; flit defaults to zero so nothing
    // lingers past the cycle it was emitted in.
    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
        len_d   = len_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        flit_d  = '0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid_i) begin
                    dest_d  = bus.req_dest_i;
                    len_d   = bus.req_len_i;
                    state_d = HEAD;
                end
            end
            HEAD: begin
                // Header waits out back-pressure; nothing is emitted while full.
                if (!bus.full_i) begin
                    flit_d = {2'b11, dest_q, SRC_ID, len_q, 4'b0000};
                    if (len_q == 3'd0) begin
                        state_d = IDLE;
                        cnt_d   = cnt_q + 8'd1;
                    end else begin
                        rem_d   = len_q;
                        state_d = BODY;
                    end
                end
            end
            BODY: begin
                // Payload bubbles simply stall here; there is no timeout.
                if (bus.pay_valid_i && !bus.full_i) begin
                    flit_d = {2'b10, bus.pay_data_i};
                    rem_d  = rem_q - 3'd1;
                    if (rem_q == 3'd1) begin
                        state_d = IDLE;
                        cnt_d   = cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any packet in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            dest_q  <= '0;
            len_q   <= '0;
            rem_q   <= '0;
            flit_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
            flit_q  <= flit_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_local_injector.sv
// Directed bench for local_injector with SRC_ID=13 and hand-computed flits.
module tb_local_injector;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;

    local_injector_if bus();

    local_injector #(.SRC_ID(4'd13)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance one rising edge, leaving time to sample registered outputs.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Request dest=14 len=2, bodies 0x1234/0x0ABC; header 0x1F6A0 with SRC_ID=13.
    task automatic pkt_basic(input logic [7:0] cnt_exp, input string tag);
        bus.req_valid_i = 1'b1; bus.req_dest_i = 4'd14; bus.req_len_i = 3'd2;
        bus.pay_valid_i = 1'b1; bus.pay_data_i = 15'h1234;
        #1 chk({tag, " req_ready"}, 32'(bus.req_ready_o), 32'd1);
        step();                                   // accepted -> HEAD
        bus.req_valid_i = 1'b0;
        chk({tag, " accept flit"}, 32'(bus.flit_o), 32'h0);
        chk({tag, " pay_ready HEAD"}, 32'(bus.pay_ready_o), 32'd0);
        step();
        chk({tag, " header"}, 32'(bus.flit_o), 32'h1F6A0);
        step();
        chk({tag, " body0"}, 32'(bus.flit_o), 32'h11234);
        bus.pay_data_i = 15'h0ABC;
        step();
        chk({tag, " body1"}, 32'(bus.flit_o), 32'h10ABC);
        chk({tag, " cnt"}, 32'(bus.pkt_cnt_o), 32'(cnt_exp));
        chk({tag, " busy low"}, 32'(bus.busy_o), 32'd0);
        bus.pay_valid_i = 1'b0;
        step();
        chk({tag, " flit cleared"}, 32'(bus.flit_o), 32'h0);
    endtask

    initial begin
        bus.req_valid_i = 1'b0; bus.req_dest_i = '0; bus.req_len_i = '0;
        bus.pay_valid_i = 1'b0; bus.pay_data_i = '0; bus.full_i = 1'b0;
        #12;
        chk("reset flit", 32'(bus.flit_o), 32'h0);
        chk("reset busy", 32'(bus.busy_o), 32'd0);
        chk("reset cnt",  32'(bus.pkt_cnt_o), 32'd0);
        chk("reset pay_ready", 32'(bus.pay_ready_o), 32'd0);
        @(negedge clk); rst = 1'b1;
        step();

        // Basic 3-flit packet
        pkt_basic(8'd1, "basic");

        // len=0: header only, dest=5 -> 0x1AE80
        bus.req_valid_i = 1'b1; bus.req_dest_i = 4'd5; bus.req_len_i = 3'd0;
        step();
        bus.req_valid_i = 1'b0;
        step();
        chk("len0 header", 32'(bus.flit_o), 32'h1AE80);
        chk("len0 busy",   32'(bus.busy_o), 32'd0);
        chk("len0 cnt",    32'(bus.pkt_cnt_o), 32'd2);
        step();
        chk("len0 single", 32'(bus.flit_o), 32'h0);

        // Back-pressure in HEAD: dest=1 len=1 -> header 0x18E90
        bus.req_valid_i = 1'b1; bus.req_dest_i = 4'd1; bus.req_len_i = 3'd1;
        step();
        bus.req_valid_i = 1'b0; bus.full_i = 1'b1;
        bus.pay_valid_i = 1'b1; bus.pay_data_i = 15'h7FFF;
        for (int i = 0; i < 3; i++) begin
            #1 chk("full pay_ready", 32'(bus.pay_ready_o), 32'd0);
            step();
            chk("full flit", 32'(bus.flit_o), 32'h0);
            chk("full busy", 32'(bus.busy_o), 32'd1);
        end
        bus.full_i = 1'b0;
        step();
        chk("full header", 32'(bus.flit_o), 32'h18E90);
        // Back-pressure in BODY also blocks the payload
        bus.full_i = 1'b1;
        #1 chk("body full pay_ready", 32'(bus.pay_ready_o), 32'd0);
        step();
        chk("body full flit", 32'(bus.flit_o), 32'h0);
        bus.full_i = 1'b0;
        #1 chk("body pay_ready", 32'(bus.pay_ready_o), 32'd1);
        step();
        chk("full body", 32'(bus.flit_o), 32'h17FFF);
        chk("full cnt",  32'(bus.pkt_cnt_o), 32'd3);
        bus.pay_valid_i = 1'b0;

        // Payload bubble: dest=2 len=3 -> header 0x196B0
        bus.req_valid_i = 1'b1; bus.req_dest_i = 4'd2; bus.req_len_i = 3'd3;
        step();
        bus.req_valid_i = 1'b0;
        step();
        chk("bub header", 32'(bus.flit_o), 32'h196B0);
        bus.pay_valid_i = 1'b1; bus.pay_data_i = 15'h0001;
        step();
        chk("bub body0", 32'(bus.flit_o), 32'h10001);
        bus.pay_valid_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("bub gap", 32'(bus.flit_o), 32'h0);
            chk("bub busy", 32'(bus.busy_o), 32'd1);
        end
        bus.pay_valid_i = 1'b1; bus.pay_data_i = 15'h0002;
        step();
        chk("bub body1", 32'(bus.flit_o), 32'h10002);
        bus.pay_data_i = 15'h0003;
        step();
        chk("bub body2", 32'(bus.flit_o), 32'h10003);
        chk("bub cnt",   32'(bus.pkt_cnt_o), 32'd4);
        bus.pay_valid_i = 1'b0;
        step();

        // Reset mid-BODY, asynchronous
        bus.req_valid_i = 1'b1; bus.req_dest_i = 4'd14; bus.req_len_i = 3'd2;
        step();
        bus.req_valid_i = 1'b0;
        step();
        bus.pay_valid_i = 1'b1; bus.pay_data_i = 15'h1234;
        step();
        chk("rst pre body", 32'(bus.flit_o), 32'h11234);
        #2 rst = 1'b0;
        #1;
        chk("rst flit", 32'(bus.flit_o), 32'h0);
        chk("rst busy", 32'(bus.busy_o), 32'd0);
        chk("rst cnt",  32'(bus.pkt_cnt_o), 32'd0);
        bus.pay_valid_i = 1'b0;
        @(negedge clk); rst = 1'b1;
        step();
        chk("post rst flit", 32'(bus.flit_o), 32'h0);
        pkt_basic(8'd1, "post rst");

        // Counter wrap: reset to zero, then 256 header-only packets
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        bus.req_valid_i = 1'b1; bus.req_dest_i = 4'd0; bus.req_len_i = 3'd0;
        for (int p = 0; p < 255; p++) begin
            step();
            step();
        end
        chk("wrap 255", 32'(bus.pkt_cnt_o), 32'd255);
        step();
        step();
        chk("wrap 0", 32'(bus.pkt_cnt_o), 32'd0);
        bus.req_valid_i = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
